// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizing for the memory access controller.
package mem_pkg;

    // Controller states; VERIFY is only reachable when write read-back is compiled in.
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StHold,
        StVerify,
        StResp
    } ctrlState_t;

    localparam int unsigned DefAddrW       = 16;
    localparam int unsigned DefDataW       = 16;
    localparam int unsigned DefMemDepth    = 256;
    localparam int unsigned DefReadWait    = 1;
    localparam int unsigned DefWriteCycles = 2;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding memory access controller.
// A request is accepted in IDLE, replayed onto the memory strobes for a fixed number of
// cycles and answered with a response that is held until the requester takes it.
// Optional macro MEM_ACCESS_CTRL_VERIFY_EN: every write is read back and compared.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned MEM_DEPTH    = DefMemDepth,
    parameter int unsigned READ_WAIT    = DefReadWait,
    parameter int unsigned WRITE_CYCLES = DefWriteCycles
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemIn,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] MemOut
);

    ctrlState_t        state;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] addrLat;
    logic [DATA_W-1:0] wdataLat;
    logic              writeLat;
    logic              outOfRange;

    // Addresses past the populated words are answered without touching the memory.
    assign outOfRange = 32'(req_addr) >= MEM_DEPTH;

    // Ready is a pure function of the state so a request is never taken mid-access.
    assign req_ready = (state == StIdle) && !reset;

    assign MemIn     = addrLat;
    assign WriteData = wdataLat;

    // Request sequencing: one FSM with a shared, non-wrapping wait counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            waitCnt   <= 4'd0;
            addrLat   <= '0;
            wdataLat  <= '0;
            writeLat  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        addrLat  <= req_addr;
                        wdataLat <= req_wdata;
                        writeLat <= req_write;
                        if (outOfRange) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end else if (req_write) begin
                            state    <= StWrite;
                            MemWrite <= 1'b1;
                            waitCnt  <= 4'(WRITE_CYCLES);
                        end else begin
                            state   <= StRead;
                            MemRead <= 1'b1;
                            waitCnt <= 4'(READ_WAIT);
                        end
                    end
                end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                StRead, StVerify: begin
`else
                StRead: begin
`endif
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                    // Strobe drops one cycle before sampling, giving MemOut a settle cycle.
                    if (waitCnt == 4'd1) begin
                        MemRead <= 1'b0;
                    end
                    if (waitCnt == 4'd0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        // writeLat marks a read-back of a write rather than a plain read.
                        if (writeLat) begin
                            rsp_rdata <= '0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                            rsp_err   <= (MemOut != wdataLat);
`else
                            rsp_err   <= 1'b0;
`endif
                        end else begin
                            rsp_rdata <= MemOut;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                StWrite: begin
                    if (waitCnt > 4'd1) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        waitCnt  <= 4'd0;
                        MemWrite <= 1'b0;
                        state    <= StHold;
                    end
                end
                StHold: begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                    state   <= StVerify;
                    MemRead <= 1'b1;
                    waitCnt <= 4'(READ_WAIT);
`else
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
`endif
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench with a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int RW = 1;
    localparam int WC = 2;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    localparam int ExpWrLat = WC + RW + 2;
    localparam int ExpWrRd  = RW;
`else
    localparam int ExpWrLat = WC + 1;
    localparam int ExpWrRd  = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemIn;
    logic [15:0] WriteData;
    logic [15:0] MemOut;

    int checks = 0;
    int errors = 0;

    logic [15:0] refMem [256];

    mem_access_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_DEPTH   (256),
        .READ_WAIT   (RW),
        .WRITE_CYCLES(WC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemIn    (MemIn),
        .WriteData(WriteData),
        .MemOut   (MemOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: registered read on MemRead, write on MemWrite.
    initial begin : memory
        logic [15:0] mem [256];
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[5] = 16'hBEEF;
        MemOut = 16'h0;
        forever begin
            @(posedge clock);
            if (MemWrite) begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                mem[MemIn[7:0]] = WriteData & 16'hFFFE;
`else
                mem[MemIn[7:0]] = WriteData;
`endif
            end
            if (MemRead) MemOut <= mem[MemIn[7:0]];
        end
    end

    // Reference model and per-cycle compare against the DUT outputs.
    initial begin : compare
        logic        busy, wasBusy, respSeen, prevReset, accWrite, expErr;
        logic [15:0] accAddr, accWdata, expData, stored;
        int          age, expLat, nRd, nWr, expRd, expWr;
        busy = 1'b0; respSeen = 1'b0; prevReset = 1'b0; accWrite = 1'b0; expErr = 1'b0;
        accAddr = 16'h0; accWdata = 16'h0; expData = 16'h0; stored = 16'h0;
        age = 0; expLat = 0; nRd = 0; nWr = 0; expRd = 0; expWr = 0;
        for (int i = 0; i < 256; i++) refMem[i] = 16'h0;
        refMem[5] = 16'hBEEF;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("rst_req_ready", 32'(req_ready), 32'(0));
                if (prevReset) begin
                    check("rst_memread", 32'(MemRead), 32'(0));
                    check("rst_memwrite", 32'(MemWrite), 32'(0));
                    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
                end
                busy = 1'b0;
            end else begin
                wasBusy = busy;
                check("req_ready", 32'(req_ready), 32'(!busy));
                check("strobe_excl", 32'(MemRead & MemWrite), 32'(0));
                if (busy) begin
                    age++;
                    if (MemRead) nRd++;
                    if (MemWrite) nWr++;
                    if (MemRead || MemWrite) check("mem_addr", 32'(MemIn), 32'(accAddr));
                    if (MemWrite) check("mem_wdata", 32'(WriteData), 32'(accWdata));
                    if (rsp_valid) begin
                        if (!respSeen) begin
                            check("latency", age, expLat);
                            check("read_cycles", nRd, expRd);
                            check("write_cycles", nWr, expWr);
                            respSeen = 1'b1;
                        end
                        check("rsp_rdata", 32'(rsp_rdata), 32'(expData));
                        check("rsp_err", 32'(rsp_err), 32'(expErr));
                        if (rsp_ready) busy = 1'b0;
                    end else if (respSeen) begin
                        check("rsp_valid_held", 32'(rsp_valid), 32'(1));
                        busy = 1'b0;
                    end else if (age > expLat) begin
                        check("rsp_timeout", 32'(rsp_valid), 32'(1));
                        busy = 1'b0;
                    end
                end else begin
                    check("rsp_idle", 32'(rsp_valid), 32'(0));
                end
                if (!wasBusy && req_valid) begin
                    busy = 1'b1; respSeen = 1'b0; age = -1; nRd = 0; nWr = 0;
                    accAddr = req_addr; accWdata = req_wdata; accWrite = req_write;
                    if (req_addr >= 16'd256) begin
                        expLat = 0; expRd = 0; expWr = 0; expData = 16'h0; expErr = 1'b1;
                    end else if (accWrite) begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                        stored = accWdata & 16'hFFFE;
                        expLat = WC + RW + 2; expRd = RW;
`else
                        stored = accWdata;
                        expLat = WC + 1; expRd = 0;
`endif
                        refMem[accAddr[7:0]] = stored;
                        expWr = WC; expData = 16'h0; expErr = (stored != accWdata);
                    end else begin
                        expLat = RW + 1; expRd = RW; expWr = 0;
                        expData = refMem[accAddr[7:0]]; expErr = 1'b0;
                    end
                end
            end
            prevReset = reset;
        end
    end

    // One request with rsp_ready held low for 'hold' cycles after rsp_valid appears.
    task automatic doReq(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input int hold, output logic [15:0] rd, output logic er,
                         output int lat, output int nRd, output int nWr);
        int n;
        n = 0; lat = -1; nRd = 0; nWr = 0; rd = 16'h0; er = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("accept_ready", 32'(req_ready), 32'(1));
        @(posedge clock); #1;
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
        n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 40) begin
            if (MemRead) nRd++;
            if (MemWrite) nWr++;
            n++;
            @(negedge clock);
        end
        check("rsp_arrived", 32'(rsp_valid), 32'(1));
        lat = n; rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_ready", 32'(req_ready), 32'(0));
            check("hold_valid", 32'(rsp_valid), 32'(1));
        end
        @(posedge clock); #1 rsp_ready = 1'b1;
        @(posedge clock); #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] expRd;
        logic        expErr;
    } vec_t;

    initial begin : stimulus
        logic [15:0] rd;
        logic        er;
        int          lat, nRd, nWr;
        vec_t        vecs[5];
        vecs[0] = '{1'b1, 16'h00FF, 16'hA5A4, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h00FF, 16'h0000, 16'hA5A4, 1'b0};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h7777, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 32'(req_ready), 32'(1));
        check("memin_reset", 32'(MemIn), 32'(0));
        check("wdata_reset", 32'(WriteData), 32'(0));

        doReq(1'b0, 16'h0005, 16'h0, 0, rd, er, lat, nRd, nWr);
        check("rd5_data", 32'(rd), 32'hBEEF);
        check("rd5_err", 32'(er), 32'(0));
        check("rd5_lat", lat, 2);
        check("rd5_pulses", nRd, 1);
        check("rd5_nowrite", nWr, 0);

        doReq(1'b1, 16'h0010, 16'h1234, 0, rd, er, lat, nRd, nWr);
        check("wr10_pulses", nWr, 2);
        check("wr10_rdpulses", nRd, ExpWrRd);
        check("wr10_lat", lat, ExpWrLat);
        check("wr10_err", 32'(er), 32'(0));

        doReq(1'b0, 16'h0010, 16'h0, 0, rd, er, lat, nRd, nWr);
        check("rd10_data", 32'(rd), 32'h1234);

        doReq(1'b0, 16'h0100, 16'h0, 0, rd, er, lat, nRd, nWr);
        check("oor_err", 32'(er), 32'(1));
        check("oor_data", 32'(rd), 32'(0));
        check("oor_strobes", nRd + nWr, 0);

        doReq(1'b0, 16'h0005, 16'h0, 5, rd, er, lat, nRd, nWr);
        check("hold_data", 32'(rd), 32'hBEEF);

        foreach (vecs[i]) begin
            doReq(vecs[i].wr, vecs[i].addr, vecs[i].data, i, rd, er, lat, nRd, nWr);
            check("vec_data", 32'(rd), 32'(vecs[i].expRd));
            check("vec_err", 32'(er), 32'(vecs[i].expErr));
        end

        // Reset during the second write-strobe cycle aborts the access.
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
        @(posedge clock); #1 req_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("abort_wr2_active", 32'(MemWrite), 32'(1));
        @(posedge clock); #1;
        check("abort_memwrite", 32'(MemWrite), 32'(0));
        check("abort_memread", 32'(MemRead), 32'(0));
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("abort_ready", 32'(req_ready), 32'(1));

        // A pending response is dropped by reset.
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0005;
        @(posedge clock); #1 req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("pending_valid", 32'(rsp_valid), 32'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        check("pending_dropped", 32'(rsp_valid), 32'(0));
        check("pending_rdata", 32'(rsp_rdata), 32'(0));
        reset = 1'b0;

        doReq(1'b0, 16'h0010, 16'h0, 0, rd, er, lat, nRd, nWr);
        check("post_reset_read", 32'(rd), 32'h1234);

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        doReq(1'b1, 16'h0030, 16'h0001, 0, rd, er, lat, nRd, nWr);
        check("verify_err", 32'(er), 32'(1));
        check("verify_lat", lat, 5);
`endif

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, bench did not complete", $time);
        $fatal(1, "bench timeout");
    end

endmodule
